// File: rtl/alu_muldiv.sv
// Registered ALU with iterative MIPS multiply/divide and HI/LO result registers.
// Simple ops complete in one cycle; MULT/DIV iterate once per bit behind a ready/valid handshake.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_XOR   = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 valid_q, valid_d, z_q, z_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]     out_q, out_d, hi_q, hi_d, lo_q, lo_d;

  logic                 accept, is_signed, slt;
  logic [WIDTH-1:0]     mag_a, mag_b, quo, rem;
  logic [WIDTH:0]       mul_sum, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod;

  assign ready     = (state_q == S_IDLE);
  assign accept    = start && ready;
  assign is_signed = ~ctl[0];
  assign slt       = $signed(a) < $signed(b);
  assign mag_a     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (is_signed && b[WIDTH-1]) ? -b : b;

  // acc_q is {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
  assign div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign prod     = qneg_q ? -mul_step : mul_step;
  assign quo      = qneg_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
  assign rem      = rneg_q ? -div_step[2*WIDTH-1:WIDTH] : div_step[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    dbz_d   = 1'b0;
    out_d   = out_q;
    z_d     = z_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          valid_d = 1'b1;
          case (ctl)
            OP_ADD: out_d = a + b;
            OP_AND: out_d = a & b;
            OP_NOR: out_d = ~(a | b);
            OP_OR:  out_d = a | b;
            OP_SLT: out_d = {{(WIDTH-1){1'b0}}, slt};
            OP_SUB: out_d = a - b;
            OP_XOR: out_d = a ^ b;
            OP_MULT, OP_MULTU: begin
              valid_d = 1'b0;
              state_d = S_MUL;
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              opb_d   = mag_b;
              qneg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d  = 1'b0;
              cnt_d   = '0;
            end
            OP_DIV, OP_DIVU: begin
              if (b == '0) begin
                hi_d  = a;
                lo_d  = '1;
                out_d = '1;
                dbz_d = 1'b1;
              end else begin
                valid_d = 1'b0;
                state_d = S_DIV;
                acc_d   = {{WIDTH{1'b0}}, mag_a};
                opb_d   = mag_b;
                qneg_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                rneg_d  = is_signed && a[WIDTH-1];
                cnt_d   = '0;
              end
            end
            default: out_d = '0;
          endcase
          z_d = (out_d == '0);
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = (state_q == S_MUL) ? mul_step : div_step;
        // Final iteration writes the sign-corrected result directly, so DONE carries valid
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
          valid_d = 1'b1;
          if (state_q == S_MUL) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
          out_d = lo_d;
          z_d   = (lo_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      out_q   <= '0;
      z_q     <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      out_q   <= out_d;
      z_q     <= z_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign valid       = valid_q;
  assign div_by_zero = dbz_q;
  assign out         = out_q;
  assign z           = z_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
